// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store front end placed in front of a word-addressed data memory.
// Byte addresses are turned into word indices, loads are sliced and
// sign/zero-extended, and sub-word stores (SB/SH) are done as a two-cycle
// read-modify-write because the memory can only write whole words.
// Misaligned or out-of-range requests are flagged and never reach memory.
//
// Ports:
//   clk             system clock, all state changes on the rising edge
//   SYS_reset_n     asynchronous active-low reset
//   LSU_req         access request valid from the MEM stage
//   LSU_op          0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
//   LSU_addr        byte address
//   LSU_wdata       store data (sub-word stores use the low bits)
//   LSU_rdata       extended load result
//   LSU_stall       hold the MEM stage and its LSU_* inputs this cycle
//   LSU_fault       misaligned or out-of-range access this cycle
//   LSU_bad_addr    address of the most recent faulting access
//   DMEM_address    word index, zero-extended to 32 bits
//   DMEM_data_in    word to write
//   DMEM_mem_write  write strobe
//   DMEM_mem_read   read enable
//   DMEM_data_out   combinational read data from memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = 8
) (
  input  logic        clk,
  input  logic        SYS_reset_n,
  input  logic        LSU_req,
  input  logic [2:0]  LSU_op,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic [31:0] LSU_rdata,
  output logic        LSU_stall,
  output logic        LSU_fault,
  output logic [31:0] LSU_bad_addr,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  // First byte address past the end of memory. For a power-of-two memory
  // this adds nothing over the upper-bit test, but it keeps the range check
  // honest if MEM_WORDS is ever set to a non-power-of-two.
  localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS) * 32'd4;

  typedef enum logic {
    ST_IDLE,
    ST_RMW_WR
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       merged_reg, merged_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [31:0]       bad_addr_reg;

  logic              active;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic [IDX_W-1:0]  word_idx;
  logic [7:0]        rd_byte [4];
  logic [31:0]       merged_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign word_idx = LSU_addr[IDX_W+1:2];

  // Outputs are gated by the reset pin so they drop to zero the moment reset
  // is asserted, even while a request is still held on the inputs.
  assign active = SYS_reset_n && LSU_req && (state_reg == ST_IDLE);

  always_comb begin
    misaligned = 1'b0;
    case (LSU_op)
      OP_LW, OP_SW:         misaligned = |LSU_addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = LSU_addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (|LSU_addr[31:IDX_W+2]) || (LSU_addr >= BYTE_LIMIT);
  assign fault        = active && (misaligned || out_of_range);

  // Per-lane read slicing and store merge. Each lane takes the store byte
  // when SB addresses it, or the matching half of wdata[15:0] when SH covers
  // it; otherwise the lane keeps what memory returned.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic byte_hit;
      logic half_hit;
      assign rd_byte[gi] = DMEM_data_out[8*gi +: 8];
      assign byte_hit    = (LSU_op == OP_SB) && (LSU_addr[1:0] == 2'(gi));
      assign half_hit    = (LSU_op == OP_SH) && (LSU_addr[1] == 1'(gi / 2));
      assign merged_word[8*gi +: 8] = byte_hit ? LSU_wdata[7:0] :
                                      half_hit ? LSU_wdata[8*(gi%2) +: 8] :
                                                 rd_byte[gi];
    end
  endgenerate

  assign sel_byte = rd_byte[LSU_addr[1:0]];
  assign sel_half = LSU_addr[1] ? DMEM_data_out[31:16] : DMEM_data_out[15:0];

  always_comb begin
    state_next     = state_reg;
    merged_next    = merged_reg;
    idx_next       = idx_reg;
    LSU_rdata      = 32'h0;
    LSU_stall      = 1'b0;
    DMEM_address   = 32'h0;
    DMEM_data_in   = 32'h0;
    DMEM_mem_write = 1'b0;
    DMEM_mem_read  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (active && !fault) begin
          DMEM_address = {{(32-IDX_W){1'b0}}, word_idx};
          case (LSU_op)
            OP_LW: begin
              DMEM_mem_read = 1'b1;
              LSU_rdata     = DMEM_data_out;
            end
            OP_LH: begin
              DMEM_mem_read = 1'b1;
              LSU_rdata     = {{16{sel_half[15]}}, sel_half};
            end
            OP_LHU: begin
              DMEM_mem_read = 1'b1;
              LSU_rdata     = {16'h0, sel_half};
            end
            OP_LB: begin
              DMEM_mem_read = 1'b1;
              LSU_rdata     = {{24{sel_byte[7]}}, sel_byte};
            end
            OP_LBU: begin
              DMEM_mem_read = 1'b1;
              LSU_rdata     = {24'h0, sel_byte};
            end
            OP_SW: begin
              DMEM_mem_write = 1'b1;
              DMEM_data_in   = LSU_wdata;
            end
            default: begin
              // SH/SB: read the word now, write the merged word next cycle.
              DMEM_mem_read = 1'b1;
              LSU_stall     = 1'b1;
              merged_next   = merged_word;
              idx_next      = word_idx;
              state_next    = ST_RMW_WR;
            end
          endcase
        end
      end

      ST_RMW_WR: begin
        // Inputs still hold the same store here and are deliberately ignored.
        if (SYS_reset_n) begin
          DMEM_mem_write = 1'b1;
          DMEM_data_in   = merged_reg;
          DMEM_address   = {{(32-IDX_W){1'b0}}, idx_reg};
        end
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_reg    <= ST_IDLE;
      merged_reg   <= 32'h0;
      idx_reg      <= '0;
      bad_addr_reg <= 32'h0;
    end else begin
      state_reg  <= state_next;
      merged_reg <= merged_next;
      idx_reg    <= idx_next;
      if (fault) begin
        bad_addr_reg <= LSU_addr;
      end
    end
  end

  assign LSU_fault    = fault;
  assign LSU_bad_addr = bad_addr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. A word-addressed memory model sits on
// the DMEM side. Each driven cycle pushes its expected outputs onto a
// scoreboard queue; the entry is popped and compared on the following
// falling edge. Fields expected as all-x are not constrained in that cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;
  localparam logic [31:0] XX    = 32'hxxxx_xxxx;
  localparam logic        X1    = 1'bx;

  logic        clk = 1'b0;
  logic        SYS_reset_n;
  logic        LSU_req;
  logic [2:0]  LSU_op;
  logic [31:0] LSU_addr;
  logic [31:0] LSU_wdata;
  logic [31:0] LSU_rdata;
  logic        LSU_stall;
  logic        LSU_fault;
  logic [31:0] LSU_bad_addr;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (DMEM_mem_write) mem[DMEM_address[7:0]] <= DMEM_data_in;
  end

  assign DMEM_data_out = DMEM_mem_read ? mem[DMEM_address[7:0]] : 32'h0;

  mem_access_unit #(
    .MEM_WORDS (256),
    .IDX_W     (8)
  ) dut (
    .clk            (clk),
    .SYS_reset_n    (SYS_reset_n),
    .LSU_req        (LSU_req),
    .LSU_op         (LSU_op),
    .LSU_addr       (LSU_addr),
    .LSU_wdata      (LSU_wdata),
    .LSU_rdata      (LSU_rdata),
    .LSU_stall      (LSU_stall),
    .LSU_fault      (LSU_fault),
    .LSU_bad_addr   (LSU_bad_addr),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    if (!$isunknown(exp)) begin
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [31:0] rdata,
                            input logic stall, input logic fault,
                            input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] din);
    exp_t e;
    e.tag = tag; e.rdata = rdata; e.stall = stall; e.fault = fault;
    e.rd = rd; e.wr = wr; e.addr = addr; e.din = din;
    sb_q.push_back(e);
  endtask

  task automatic compare_now();
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard: got empty queue expected an entry");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".rdata"}, LSU_rdata,      e.rdata);
      chk({e.tag, ".stall"}, {31'h0, LSU_stall},      {31'h0, e.stall});
      chk({e.tag, ".fault"}, {31'h0, LSU_fault},      {31'h0, e.fault});
      chk({e.tag, ".rd"},    {31'h0, DMEM_mem_read},  {31'h0, e.rd});
      chk({e.tag, ".wr"},    {31'h0, DMEM_mem_write}, {31'h0, e.wr});
      chk({e.tag, ".addr"},  DMEM_address,   e.addr);
      chk({e.tag, ".din"},   DMEM_data_in,   e.din);
      $display("txn %-12s req=%0b op=%0d addr=%08h wdata=%08h | rdata=%08h stall=%0b fault=%0b rd=%0b wr=%0b idx=%08h din=%08h bad=%08h",
               e.tag, LSU_req, LSU_op, LSU_addr, LSU_wdata, LSU_rdata, LSU_stall,
               LSU_fault, DMEM_mem_read, DMEM_mem_write, DMEM_address, DMEM_data_in,
               LSU_bad_addr);
    end
  endtask

  task automatic check_cyc();
    @(negedge clk);
    compare_now();
  endtask

  // Compare this cycle, then advance to just after the next rising edge.
  task automatic step();
    check_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    LSU_req   = req;
    LSU_op    = op;
    LSU_addr  = addr;
    LSU_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    SYS_reset_n = 1'b0;
    drive(1'b0, OP_LW, 32'h0, 32'h0);

    // Reset state
    expect_cyc("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cyc();
    chk("reset.bad_addr", LSU_bad_addr, 32'h0);
    @(posedge clk);
    #1;
    SYS_reset_n = 1'b1;

    // Word round trip
    drive(1'b1, OP_SW, 32'h10, 32'hDEADBEEF);
    expect_cyc("sw_10", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'hDEADBEEF);
    step();
    drive(1'b1, OP_LW, 32'h10, 32'h0);
    expect_cyc("lw_10", 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();

    // Byte store read-modify-write, followed directly by a load
    drive(1'b1, OP_SB, 32'h11, 32'h000000A5);
    expect_cyc("sb_11_rd", XX, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    expect_cyc("sb_11_wr", XX, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'hDEADA5EF);
    step();
    drive(1'b1, OP_LW, 32'h10, 32'h0);
    expect_cyc("lw_after_sb", 32'hDEADA5EF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();

    // Extension patterns on word 4 = 0x80FF7F01
    drive(1'b1, OP_SW, 32'h10, 32'h80FF7F01);
    expect_cyc("sw_ext", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h80FF7F01);
    step();
    drive(1'b1, OP_LB, 32'h13, 32'h0);
    expect_cyc("lb_13", 32'hFFFFFF80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    drive(1'b1, OP_LBU, 32'h13, 32'h0);
    expect_cyc("lbu_13", 32'h00000080, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    drive(1'b1, OP_LH, 32'h12, 32'h0);
    expect_cyc("lh_12", 32'hFFFF80FF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    drive(1'b1, OP_LHU, 32'h12, 32'h0);
    expect_cyc("lhu_12", 32'h000080FF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    drive(1'b1, OP_LB, 32'h10, 32'h0);
    expect_cyc("lb_10", 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    drive(1'b1, OP_LH, 32'h10, 32'h0);
    expect_cyc("lh_10", 32'h00007F01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();

    // Halfword store into the upper lane; upper wdata bits must be ignored
    drive(1'b1, OP_SH, 32'h12, 32'hABCD1234);
    expect_cyc("sh_12_rd", XX, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    expect_cyc("sh_12_wr", XX, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h12347F01);
    step();
    drive(1'b1, OP_LW, 32'h10, 32'h0);
    expect_cyc("lw_after_sh", 32'h12347F01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();

    // Faults
    drive(1'b1, OP_LW, 32'h12, 32'h0);
    expect_cyc("lw_misalign", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, XX, XX);
    step();
    chk("bad_addr_12", LSU_bad_addr, 32'h12);
    drive(1'b1, OP_SH, 32'h401, 32'h0);
    expect_cyc("sh_misalign", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, XX, XX);
    step();
    chk("bad_addr_401", LSU_bad_addr, 32'h401);
    drive(1'b1, OP_SW, 32'h400, 32'h12345678);
    expect_cyc("sw_range", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, XX, XX);
    step();
    chk("bad_addr_400", LSU_bad_addr, 32'h400);
    drive(1'b1, OP_LB, 32'h80000003, 32'h0);
    expect_cyc("lb_range_hi", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, XX, XX);
    step();
    chk("bad_addr_hi", LSU_bad_addr, 32'h80000003);

    // No fault: bad address holds, memory untouched by the faulting SW
    drive(1'b1, OP_LW, 32'h10, 32'h0);
    expect_cyc("lw_post_flt", 32'h12347F01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, XX);
    step();
    chk("bad_addr_hold", LSU_bad_addr, 32'h80000003);

    // Idle cycle: everything quiet
    drive(1'b0, OP_SB, 32'h10, 32'hFFFFFFFF);
    expect_cyc("idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset in the middle of a read-modify-write
    drive(1'b1, OP_SW, 32'h20, 32'h11223344);
    expect_cyc("sw_20", 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h11223344);
    step();
    drive(1'b1, OP_SB, 32'h20, 32'h00000055);
    expect_cyc("sb_20_rd", XX, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8, XX);
    step();
    expect_cyc("sb_20_wr", XX, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h11223355);
    check_cyc();
    #1;
    SYS_reset_n = 1'b0;
    #1;
    expect_cyc("reset_async", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    compare_now();
    chk("reset_async.bad_addr", LSU_bad_addr, 32'h0);
    @(posedge clk);
    #1;
    expect_cyc("reset_held", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    compare_now();
    SYS_reset_n = 1'b1;
    drive(1'b1, OP_LW, 32'h20, 32'h0);
    expect_cyc("lw_20", 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, XX);
    step();
    drive(1'b0, OP_LW, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-addressed data memory in the MIPS datapath, fed by the MEM pipeline stage.
- Converts byte addresses to word indices and performs LW/LH/LHU/LB/LBU extraction with sign or zero extension.
- Implements SB/SH as a two-cycle read-modify-write, because the memory only writes whole words; stalls the pipeline while it does so.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; valid byte addresses are 0 .. 4*MEM_WORDS-1.
- IDX_W, 8, width of the word index driven to memory; log2(MEM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- SYS_reset_n  in  1  asynchronous active-low reset.
- LSU_req  in  1  memory-access request valid from MEM stage.
- LSU_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- LSU_addr  in  32  byte address.
- LSU_wdata  in  32  store data; sub-word stores use low bits.
- LSU_rdata  out  32  extended load result.
- LSU_stall  out  1  hold MEM stage and freeze LSU_* inputs this cycle.
- LSU_fault  out  1  misaligned or out-of-range access this cycle.
- LSU_bad_addr  out  32  address of most recent faulting access.
- DMEM_address  out  32  word index, zero-extended from IDX_W bits.
- DMEM_data_in  out  32  word to write.
- DMEM_mem_write  out  1  write strobe.
- DMEM_mem_read  out  1  read enable.
- DMEM_data_out  in  32  combinational read data; 0 when read enable is low.

Behaviour:
- Byte order is little-endian: byte k of a word occupies bits [8k+7:8k].
- Word index is LSU_addr[IDX_W+1:2].
- Fault conditions, evaluated combinationally when LSU_req=1 and state=IDLE:
  - Misaligned: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]=1.
  - Out of range: addr[31:IDX_W+2]!=0.
- On a fault:
  - LSU_fault=1 in the same cycle; no mem_read or mem_write; LSU_rdata=0; LSU_stall=0.
  - LSU_bad_addr <= LSU_addr at the next posedge; the register holds its value until the next fault.
- FSM states: IDLE and RMW_WR.
- IDLE:
  - No request: every DMEM output is 0, stall=0, rdata=0.
  - Load: mem_read=1. rdata is the selected byte or half, sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the full word. Zero added latency, stall=0.
  - SW: mem_write=1 and data_in=wdata in the same cycle; stall=0.
  - SB/SH, no fault: mem_read=1 and stall=1. At the posedge, latch the merged word (DMEM_data_out with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]) and the word index, then go to RMW_WR.
- RMW_WR:
  - Drive mem_write=1, data_in=merged word, address=latched index; mem_read=0, stall=0.
  - LSU_* inputs are ignored (they still hold the same store). Return to IDLE at the next posedge.
- Cost: a sub-word store takes 2 cycles with 1 stall cycle. All other operations take 1 cycle with no stall.
- Reset (asynchronous, SYS_reset_n=0):
  - State=IDLE, merged word and index registers = 0, LSU_bad_addr=0.
  - All outputs 0: stall=0, fault=0, mem_write=0, mem_read=0.
  - Reset during RMW_WR aborts the write; memory is left unmodified.
- Back-to-back: a request presented in the cycle after RMW_WR is handled normally from IDLE. No bubble beyond the single stall cycle.
- Undefined ops cannot occur; all 8 encodings are assigned.

Test Plan:
- Reset: assert SYS_reset_n=0 mid-run -> all outputs 0 immediately (asynchronous); LSU_bad_addr=0.
- Word round trip: SW addr 0x10 data 0xDEADBEEF -> index 4, write strobe for 1 cycle, no stall. Then LW 0x10 -> rdata 0xDEADBEEF in the same cycle.
- Byte store RMW: word 4 = 0xDEADBEEF, then SB addr 0x11 wdata 0x000000A5 -> cycle 1: stall=1, mem_read=1. Cycle 2: mem_write=1, data_in 0xDEADA5EF. A following LW 0x10 returns 0xDEADA5EF.
- Extension: word 4 = 0x80FF7F01 ->
  - LB 0x13 = 0xFFFFFF80; LBU 0x13 = 0x00000080.
  - LH 0x12 = 0xFFFF80FF; LHU 0x12 = 0x000080FF.
  - LB 0x10 = 0x00000001.
- Faults: LW 0x12 -> fault=1 with no DMEM strobes; LSU_bad_addr=0x12 next cycle. SH 0x401 -> fault (misaligned). SW 0x400 -> fault (out of range); LSU_bad_addr=0x400.
- Reset mid-RMW: SB 0x20 data 0x55 with word 8 = 0x11223344; pull SYS_reset_n low during RMW_WR -> no write occurs, word 8 still 0x11223344, state IDLE.
